// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, parity encodings and oversampling factor for the UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;
  localparam int OVS = 16;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: 2^FIFO_W deep TX FIFO; writes while full are dropped even if a pop happens that cycle.
module uart_fifo #(
  parameter int DBIT = 8,
  parameter int FIFO_W = 2
) (
  input logic clk,
  input logic reset,
  input logic wr,
  input logic rd,
  input logic [DBIT-1:0] w_data,
  output logic [DBIT-1:0] r_data,
  output logic full,
  output logic empty,
  output logic [FIFO_W:0] level
);
  localparam logic [FIFO_W:0] DEPTH = (FIFO_W+1)'(2**FIFO_W);
  logic [DBIT-1:0] mem [2**FIFO_W];
  logic [FIFO_W-1:0] wp, rp;
  logic wr_ok, rd_ok;
  assign full = level == DEPTH;
  assign empty = level == '0;
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;
  assign r_data = mem[rp];
  always_ff @(posedge clk)
    if (wr_ok) mem[wp] <= w_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      level <= level + (FIFO_W+1)'(wr_ok) - (FIFO_W+1)'(rd_ok);
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: FIFO-buffered UART transmitter with runtime baud divisor and 1/2 stop bits.
// Define UART_TX_PARITY_EN to build the optional even/odd parity bit.
module uart_tx_ctrl #(
  parameter int DBIT = 8,
  parameter int FIFO_W = 2,
  parameter int DVSR_BIT = 11
) (
  input logic clk,
  input logic reset,
  input logic [DVSR_BIT-1:0] dvsr,
  input logic [1:0] parity_mode,
  input logic stop2,
  input logic wr_uart,
  input logic [DBIT-1:0] w_data,
  output logic tx_full,
  output logic tx_empty,
  output logic [FIFO_W:0] tx_level,
  output logic tx_busy,
  output logic tx
);
  import uart_pkg::*;
  localparam int NW = $clog2(DBIT);
  state_t state, state_n;
  logic [DVSR_BIT-1:0] cnt, dv_q;
  logic s_tick, load, stop2_q, stop2_n, tx_q, tx_n;
  logic [4:0] s, s_n, s_last;
  logic [NW-1:0] n, n_n;
  logic [DBIT-1:0] b, b_n, r_data;
`ifdef UART_TX_PARITY_EN
  logic pen_q, pen_n, par_q, par_n;
`else
  logic unused_par;
  assign unused_par = ^parity_mode;
`endif
  uart_fifo #(.DBIT(DBIT), .FIFO_W(FIFO_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr(wr_uart),
    .rd(load),
    .w_data(w_data),
    .r_data(r_data),
    .full(tx_full),
    .empty(tx_empty),
    .level(tx_level)
  );
  // divisor is sampled only at wrap so a live change never truncates a tick period
  assign s_tick = cnt == dv_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      dv_q <= '0;
    end else if (s_tick) begin
      cnt <= '0;
      dv_q <= dvsr;
    end else begin
      cnt <= cnt + 1'b1;
    end
  assign s_last = (state == STOP && stop2_q) ? 5'(2*OVS-1) : 5'(OVS-1);
  assign tx_busy = state != IDLE;
  assign tx = tx_q;
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    b_n = b;
    stop2_n = stop2_q;
    load = 1'b0;
`ifdef UART_TX_PARITY_EN
    pen_n = pen_q;
    par_n = par_q;
`endif
    if (state == IDLE)
      load = !tx_empty;
    else if (s_tick && s != s_last)
      s_n = s + 1'b1;
    else if (s_tick) begin
      s_n = '0;
      if (state == START) begin
        state_n = DATA;
        n_n = '0;
      end else if (state == DATA) begin
        b_n = b >> 1;
        n_n = n + 1'b1;
        if (n == NW'(DBIT-1))
`ifdef UART_TX_PARITY_EN
          state_n = pen_q ? PARITY : STOP;
`else
          state_n = STOP;
`endif
      end else if (state == STOP) begin
        state_n = IDLE;
        load = !tx_empty;
      end else
        state_n = STOP;
    end
    // frame format is frozen at pop time
    if (load) begin
      state_n = START;
      s_n = '0;
      b_n = r_data;
      stop2_n = stop2;
`ifdef UART_TX_PARITY_EN
      pen_n = parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
      par_n = ^r_data ^ (parity_mode == PAR_ODD);
`endif
    end
    // line level is derived from the next state so tx stays aligned with tx_busy
    tx_n = state_n == START ? 1'b0 :
           state_n == DATA ? b_n[0] :
`ifdef UART_TX_PARITY_EN
           state_n == PARITY ? par_n :
`endif
           1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
      stop2_q <= 1'b0;
      tx_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      pen_q <= 1'b0;
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      s <= s_n;
      n <= n_n;
      b <= b_n;
      stop2_q <= stop2_n;
      tx_q <= tx_n;
`ifdef UART_TX_PARITY_EN
      pen_q <= pen_n;
      par_q <= par_n;
`endif
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl (parity cases when UART_TX_PARITY_EN is defined).
module tb_uart_tx_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [10:0] dvsr = '0;
  logic [1:0] parity_mode = 2'b00;
  logic stop2 = 1'b0;
  logic wr_uart = 1'b0;
  logic [7:0] w_data = '0;
  logic tx_full, tx_empty, tx_busy, tx;
  logic [2:0] tx_level;
  int errors = 0;
  int checks = 0;
  logic txs [800];
  logic bs [800];
  logic [7:0] bp [5] = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
  uart_tx_ctrl #(.DBIT(8), .FIFO_W(2), .DVSR_BIT(11)) dut (
    .clk(clk),
    .reset(reset),
    .dvsr(dvsr),
    .parity_mode(parity_mode),
    .stop2(stop2),
    .wr_uart(wr_uart),
    .w_data(w_data),
    .tx_full(tx_full),
    .tx_empty(tx_empty),
    .tx_level(tx_level),
    .tx_busy(tx_busy),
    .tx(tx)
  );
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic put(input logic [7:0] d);
    wr_uart = 1'b1;
    w_data = d;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask
  task automatic wait_start(input int lim);
    int k = 0;
    while (tx !== 1'b0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("start bit seen", int'(tx === 1'b0), 1);
  endtask
  task automatic capture(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      txs[k] = tx;
      bs[k] = tx_busy;
      @(negedge clk);
    end
  endtask
  function automatic int ones(input int a, input int len);
    int c = 0;
    for (int k = a; k < a + len; k++) c += int'(txs[k] === 1'b1);
    return c;
  endfunction
  function automatic int busy_cnt(input int len);
    int c = 0;
    for (int k = 0; k < len; k++) c += int'(bs[k] === 1'b1);
    return c;
  endfunction
  task automatic check_frame(input string tag, input int off, input logic [7:0] d, input int par, input bit s2);
    int e [12];
    int nb;
    e[0] = 0;
    for (int i = 0; i < 8; i++) e[i+1] = int'(d[i]);
    nb = 9;
    if (par >= 0) begin
      e[nb] = par;
      nb++;
    end
    e[nb] = 1;
    nb++;
    if (s2) begin
      e[nb] = 1;
      nb++;
    end
    for (int j = 0; j < nb; j++)
      check($sformatf("%s bit%0d ones", tag, j), ones(off + 16*j, 16), e[j] * 16);
  endtask
  initial begin
    int k, lows, bsy;
    #12;
    check("rst tx", int'(tx), 1);
    check("rst busy", int'(tx_busy), 0);
    check("rst empty", int'(tx_empty), 1);
    check("rst full", int'(tx_full), 0);
    check("rst level", int'(tx_level), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    put(8'h55);
    wait_start(50);
    capture(200);
    check_frame("8N1 55", 0, 8'h55, -1, 1'b0);
    check("8N1 busy cycles", busy_cnt(200), 160);
    check("8N1 idle after", ones(160, 40), 40);
`ifdef UART_TX_PARITY_EN
    parity_mode = 2'b01;
    put(8'h07);
    wait_start(50);
    capture(200);
    check_frame("even 07", 0, 8'h07, 1, 1'b0);
    check("even busy cycles", busy_cnt(200), 176);
    parity_mode = 2'b10;
    put(8'h07);
    wait_start(50);
    capture(200);
    check_frame("odd 07", 0, 8'h07, 0, 1'b0);
    check("odd busy cycles", busy_cnt(200), 176);
    parity_mode = 2'b00;
`else
    parity_mode = 2'b01;
    put(8'h07);
    wait_start(50);
    capture(200);
    check_frame("noparity 07", 0, 8'h07, -1, 1'b0);
    check("noparity busy cycles", busy_cnt(200), 160);
    parity_mode = 2'b00;
`endif
    put(8'h0F);
    wait_start(50);
    stop2 = 1'b1;
    parity_mode = 2'b01;
    capture(200);
    check_frame("midchg 0F", 0, 8'h0F, -1, 1'b0);
    check("midchg busy cycles", busy_cnt(200), 160);
    parity_mode = 2'b00;
    stop2 = 1'b1;
    put(8'hA3);
    put(8'h3C);
    wait_start(50);
    capture(400);
    check_frame("s2 A3", 0, 8'hA3, -1, 1'b1);
    check_frame("s2 3C", 176, 8'h3C, -1, 1'b1);
    check("s2 busy cycles", busy_cnt(400), 352);
    stop2 = 1'b0;
    dvsr = 11'd100;
    put(8'h11);
    @(negedge clk);
    check("bp head popped", int'(tx_empty), 1);
    for (int i = 0; i < 5; i++) begin
      put(bp[i]);
      check($sformatf("bp level after wr%0d", i + 1), int'(tx_level), i < 4 ? i + 1 : 4);
      check($sformatf("bp full after wr%0d", i + 1), int'(tx_full), i >= 3 ? 1 : 0);
    end
    dvsr = 11'd0;
    k = 0;
    while (tx_level != 3'd3 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("bp first pop", int'(tx_level), 3);
    capture(700);
    for (int i = 0; i < 4; i++)
      check_frame($sformatf("bp frame%0d", i), 160*i, bp[i], -1, 1'b0);
    check("bp busy cycles", busy_cnt(700), 640);
    check("bp idle after", ones(640, 60), 60);
    put(8'hF0);
    put(8'h0F);
    wait_start(50);
    repeat (69) @(negedge clk);
    check("pre-rst tx bit3", int'(tx), 0);
    check("pre-rst level", int'(tx_level), 1);
    #2 reset = 1'b0;
    #1;
    check("mid rst tx", int'(tx), 1);
    check("mid rst busy", int'(tx_busy), 0);
    check("mid rst empty", int'(tx_empty), 1);
    check("mid rst level", int'(tx_level), 0);
    @(negedge clk);
    reset = 1'b1;
    lows = 0;
    bsy = 0;
    repeat (300) begin
      @(negedge clk);
      lows += int'(tx !== 1'b1);
      bsy += int'(tx_busy !== 1'b0);
    end
    check("post rst tx low samples", lows, 0);
    check("post rst busy samples", bsy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
